// File: rtl/rr_arb8_ctrl_if.sv
// rtl/rr_arb8_ctrl_if.sv - request/grant bundle between the requesters and rr_arb8_ctrl
interface rr_arb8_ctrl_if;
  logic [7:0] pi_req;
  logic       pi_release;
  logic [7:0] po_grant;
  logic [2:0] po_grant_idx;
  logic       po_grant_vld;
  logic       po_tmo;

  modport master (
    output pi_req, pi_release,
    input  po_grant, po_grant_idx, po_grant_vld, po_tmo
  );

  modport slave (
    input  pi_req, pi_release,
    output po_grant, po_grant_idx, po_grant_vld, po_tmo
  );
endinterface

// File: rtl/rr_arb8_ctrl.sv
// rtl/rr_arb8_ctrl.sv - 8-way round-robin arbiter with registered one-hot grant
// Optional forced revoke after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module rr_arb8_ctrl #(
  parameter int MAX_HOLD = 255,
  parameter int TMO_W    = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  rr_arb8_ctrl_if.slave bus
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  if (MAX_HOLD < 1 || MAX_HOLD > 255 || (MAX_HOLD >> TMO_W) != 0) begin : g_bad_param
    $error("rr_arb8_ctrl: MAX_HOLD must be 1..255 and representable in TMO_W bits");
  end

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [2:0] r_idx;
  logic [7:0] r_grant;
  logic       r_vld;

  logic [2:0] w_sel;
  logic [2:0] w_cand;
  logic       w_any;
  logic       w_end;

  // Walk offsets high to low so the candidate nearest after r_ptr wins; offset 8 is r_ptr itself.
  always_comb begin
    w_sel  = r_ptr;
    w_cand = r_ptr;
    for (int i = 8; i >= 1; i--) begin
      w_cand = r_ptr + 3'(i);
      if (bus.pi_req[w_cand]) begin
        w_sel = w_cand;
      end
    end
  end

  assign w_any = |bus.pi_req;
  assign w_end = bus.pi_release || !bus.pi_req[r_idx];

`ifdef ARB_TIMEOUT_EN
  logic [TMO_W-1:0] r_hold_cnt;
  logic             r_tmo;
  logic             w_expire;

  // Counter holds completed grant cycles, so the cycle in flight is number r_hold_cnt+1.
  assign w_expire = (r_hold_cnt >= TMO_W'(MAX_HOLD - 1));
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 3'd7;
      r_idx   <= 3'd0;
      r_grant <= 8'h00;
      r_vld   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt <= '0;
      r_tmo      <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_tmo <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_idx   <= w_sel;
            r_grant <= 8'd1 << w_sel;
            r_vld   <= 1'b1;
            r_state <= S_GRANT;
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt <= '0;
`endif
          end
        end
        S_GRANT: begin
          if (w_end) begin
            r_grant <= 8'h00;
            r_vld   <= 1'b0;
            r_ptr   <= r_idx;
            r_state <= S_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (w_expire) begin
            r_grant <= 8'h00;
            r_vld   <= 1'b0;
            r_ptr   <= r_idx;
            r_state <= S_IDLE;
            r_tmo   <= 1'b1;
          end else if (r_hold_cnt != {TMO_W{1'b1}}) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.po_grant     = r_grant;
  assign bus.po_grant_idx = r_idx;
  assign bus.po_grant_vld = r_vld;
`ifdef ARB_TIMEOUT_EN
  assign bus.po_tmo       = r_tmo;
`else
  assign bus.po_tmo       = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// tb/tb_rr_arb8_ctrl.sv - directed vector bench for rr_arb8_ctrl (ARB_TIMEOUT_EN selects MAX_HOLD=4 checks)
module tb_rr_arb8_ctrl;

`ifdef ARB_TIMEOUT_EN
  localparam int P_MAX_HOLD = 4;
`else
  localparam int P_MAX_HOLD = 255;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  rr_arb8_ctrl_if u_if();

  rr_arb8_ctrl #(.MAX_HOLD(P_MAX_HOLD), .TMO_W(8)) u_dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       rel;
    logic [7:0] grant;
    logic [2:0] idx;
    logic       vld;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [7:0] eg, input logic [2:0] ei,
                       input logic ev, input logic et);
    n_checks++;
    if ({u_if.po_grant, u_if.po_grant_idx, u_if.po_grant_vld, u_if.po_tmo} !== {eg, ei, ev, et}) begin
      n_errors++;
      $display("FAIL %s: got grant=%h idx=%0d vld=%b tmo=%b, want grant=%h idx=%0d vld=%b tmo=%b",
               name, u_if.po_grant, u_if.po_grant_idx, u_if.po_grant_vld, u_if.po_tmo,
               eg, ei, ev, et);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    // {req, release} -> expected {grant, idx, vld} after the next edge
    vecs[0]  = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b1};
    vecs[1]  = '{8'h01, 1'b1, 8'h00, 3'd0, 1'b0};
    vecs[2]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[3]  = '{8'h28, 1'b0, 8'h08, 3'd3, 1'b1};
    vecs[4]  = '{8'h28, 1'b0, 8'h08, 3'd3, 1'b1};
    vecs[5]  = '{8'h20, 1'b0, 8'h00, 3'd3, 1'b0};
    vecs[6]  = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1};
    vecs[7]  = '{8'h20, 1'b1, 8'h00, 3'd5, 1'b0};
    vecs[8]  = '{8'h80, 1'b0, 8'h80, 3'd7, 1'b1};
    vecs[9]  = '{8'h81, 1'b1, 8'h00, 3'd7, 1'b0};
    vecs[10] = '{8'h81, 1'b0, 8'h01, 3'd0, 1'b1};
    vecs[11] = '{8'h81, 1'b1, 8'h00, 3'd0, 1'b0};
    vecs[12] = '{8'h81, 1'b0, 8'h80, 3'd7, 1'b1};
    vecs[13] = '{8'h83, 1'b0, 8'h80, 3'd7, 1'b1};
    vecs[14] = '{8'h01, 1'b1, 8'h00, 3'd7, 1'b0};
    vecs[15] = '{8'h00, 1'b1, 8'h00, 3'd7, 1'b0};
    vecs[16] = '{8'h06, 1'b1, 8'h02, 3'd1, 1'b1};
    vecs[17] = '{8'h06, 1'b1, 8'h00, 3'd1, 1'b0};
    vecs[18] = '{8'h06, 1'b0, 8'h04, 3'd2, 1'b1};
    vecs[19] = '{8'h00, 1'b1, 8'h00, 3'd2, 1'b0};

    rst = 1'b1;
    u_if.pi_req = 8'h00;
    u_if.pi_release = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      u_if.pi_req = vecs[i].req;
      u_if.pi_release = vecs[i].rel;
      step();
      check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].idx, vecs[i].vld, 1'b0);
    end

    // Full round robin from a fresh reset: owners 0..7 then 0, 3 cycles each, one gap.
    u_if.pi_req = 8'h00;
    u_if.pi_release = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    u_if.pi_req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 3; c++) begin
        step();
        check($sformatf("rr_own%0d_c%0d", k, c), 8'd1 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
      end
      u_if.pi_release = 1'b1;
      step();
      check($sformatf("rr_gap%0d", k), 8'h00, 3'(k % 8), 1'b0, 1'b0);
      u_if.pi_release = 1'b0;
    end

    // Asynchronous reset in the middle of channel 6's grant.
    u_if.pi_req = 8'h40;
    step();
    check("pre_rst_own6", 8'h40, 3'd6, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    u_if.pi_req = 8'h41;
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_rst_own0", 8'h01, 3'd0, 1'b1, 1'b0);
    u_if.pi_release = 1'b1;
    step();
    check("post_rst_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    u_if.pi_release = 1'b0;
    u_if.pi_req = 8'h04;

`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("tmo_hold%0d", c), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    step();
    check("tmo_revoke", 8'h00, 3'd2, 1'b0, 1'b1);
    step();
    check("tmo_regrant", 8'h04, 3'd2, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("tmo_hold2_%0d", c), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    u_if.pi_release = 1'b1;
    step();
    check("tmo_rel_same_cycle", 8'h00, 3'd2, 1'b0, 1'b0);
    u_if.pi_release = 1'b0;
`else
    for (int c = 0; c < 120; c++) begin
      step();
      check($sformatf("persist%0d", c), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    u_if.pi_release = 1'b1;
    step();
    check("persist_rel", 8'h00, 3'd2, 1'b0, 1'b0);
    u_if.pi_release = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
